// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one iterative 32x32 multiplier among NUM_REQ requesters.
// Optional watchdog (resp_err, WDOG_CYCLES) is compiled in with `define MULT_ARB_WATCHDOG_EN.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
`ifdef MULT_ARB_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [63:0]             resp_product,
  output logic                    resp_err,
  output logic                    mult_start,
  output logic [31:0]             mult_a,
  output logic [31:0]             mult_b,
  input  logic                    mult_busy,
  input  logic [63:0]             mult_product
);

  localparam int unsigned LP_N = NUM_REQ;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_RUN,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_found;
  logic [NUM_REQ-1:0]  w_onehot;
  logic                w_accept;
  logic                w_grant_ok;
  logic                w_timeout;
  logic [31:0]         r_mult_a;
  logic [31:0]         r_mult_b;
  logic [ID_W-1:0]     r_resp_id;
  logic [63:0]         r_resp_product;

  assign mult_a       = r_mult_a;
  assign mult_b       = r_mult_b;
  assign resp_id      = r_resp_id;
  assign resp_product = r_resp_product;
  assign w_accept     = |req_ready;

`ifdef MULT_ARB_WATCHDOG_EN
  localparam int unsigned LP_WD_W = $clog2(WDOG_CYCLES + 1);

  logic [LP_WD_W-1:0] r_wdog;
  logic               r_resp_err;

  assign w_timeout  = (r_wdog >= LP_WD_W'(WDOG_CYCLES - 1));
  // A timed-out multiplier may still be busy; never start it again until it idles.
  assign w_grant_ok = ~mult_busy;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT_BUSY || r_state == S_RUN) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign w_grant_ok = 1'b1;
  assign resp_err   = 1'b0;
`endif

  // First asserted req_valid searching upward from the pointer, with wrap.
  always_comb begin
    int unsigned v_sum;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 0; k < LP_N; k++) begin
      v_sum = 32'(r_ptr) + k;
      if (v_sum >= LP_N) v_sum = v_sum - LP_N;
      if (!w_found && req_valid[ID_W'(v_sum)]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(v_sum);
      end
    end
    w_onehot = w_found ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_timeout)      w_state_nxt = S_RESP;
        else if (mult_busy) w_state_nxt = S_RUN;
      end
      S_RUN:       if (!mult_busy || w_timeout) w_state_nxt = S_RESP;
      S_RESP:      if (resp_ready) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    mult_start = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      S_IDLE:  if (!reset && w_grant_ok) req_ready = w_onehot;
      S_START: mult_start = 1'b1;
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr          <= '0;
      r_id           <= '0;
      r_mult_a       <= '0;
      r_mult_b       <= '0;
      r_resp_id      <= '0;
      r_resp_product <= '0;
`ifdef MULT_ARB_WATCHDOG_EN
      r_resp_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mult_a <= req_a[{w_gnt_idx, 5'd0} +: 32];
            r_mult_b <= req_b[{w_gnt_idx, 5'd0} +: 32];
            r_id     <= w_gnt_idx;
            r_ptr    <= (w_gnt_idx == ID_W'(LP_N - 1)) ? '0 : w_gnt_idx + 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          if (w_timeout) begin
            r_resp_product <= '0;
            r_resp_id      <= r_id;
`ifdef MULT_ARB_WATCHDOG_EN
            r_resp_err     <= 1'b1;
`endif
          end
        end
        S_RUN: begin
          if (!mult_busy) begin
            r_resp_product <= mult_product;
            r_resp_id      <= r_id;
`ifdef MULT_ARB_WATCHDOG_EN
            r_resp_err     <= 1'b0;
`endif
          end else if (w_timeout) begin
            r_resp_product <= '0;
            r_resp_id      <= r_id;
`ifdef MULT_ARB_WATCHDOG_EN
            r_resp_err     <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
